// File: rtl/prbs31_pkg.sv
// Shared definitions for the PRBS31 (x^31 + x^28 + 1) generator and checker.
package prbs31_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 31;
  localparam int TAP_B    = 28;

  // s[0] is the newest bit, so tap n lives at index n-1.
  function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] s);
    return s[TAP_A-1] ^ s[TAP_B-1];
  endfunction

endpackage

// File: rtl/prbs31_lfsr_step.sv
// One PRBS31 shift step: predicted bit from the register and the shifted register.
module prbs31_lfsr_step
  import prbs31_pkg::*;
(
  input  logic [PRBS_LEN-1:0] s,
  input  logic                use_pred,
  input  logic                ext_bit,
  output logic                pred,
  output logic [PRBS_LEN-1:0] s_next
);

  logic shift_bit;

  assign pred      = prbs_predict(s);
  assign shift_bit = use_pred ? pred : ext_bit;
  assign s_next    = {s[PRBS_LEN-2:0], shift_bit};

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 receive checker: acquires lock, counts bit errors,
// and drops lock when too many errors land in one window.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int LOSS_ERRS = 8,
  parameter int WIN_LOG2  = 5,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             lost_pulse,
  output logic [CNT_W-1:0] err_count,
  output state_e           dbg_state
);

  localparam int FILL_W  = $clog2(PRBS_LEN + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WERR_W  = WIN_LOG2 + 1;

  // din_vld qualifies din; there is no backpressure. With din_vld low every
  // register holds, except the one-cycle pulses (drop) and err_clr (applies).
  state_e               state_q, state_d;
  logic [PRBS_LEN-1:0]  s_q, s_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [WIN_LOG2-1:0]  wbit_q, wbit_d;
  logic [WERR_W-1:0]    werr_q, werr_d;
  logic [CNT_W-1:0]     err_count_q, err_count_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 lost_pulse_q, lost_pulse_d;

  logic                 pred;
  logic [PRBS_LEN-1:0]  s_next;
  logic [WERR_W-1:0]    werr_inc;

  // Once locked the register free-runs on its own prediction, so a single
  // line error cannot poison the following 31 predictions.
  prbs31_lfsr_step u_step (
    .s        (s_q),
    .use_pred (state_q == LOCKED),
    .ext_bit  (din),
    .pred     (pred),
    .s_next   (s_next)
  );

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    fill_d       = fill_q;
    match_d      = match_q;
    wbit_d       = wbit_q;
    werr_d       = werr_q;
    err_count_d  = err_count_q;
    err_pulse_d  = 1'b0;
    lost_pulse_d = 1'b0;
    werr_inc     = werr_q;

    if (din_vld) begin
      s_d = s_next;
      case (state_q)
        SEARCH: begin
          if (fill_q == FILL_W'(PRBS_LEN - 1)) begin
            state_d = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        VERIFY: begin
          // An all-zero register predicts zeros forever; never trust it.
          if ((din == pred) && (s_q != '0)) begin
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
              wbit_d  = '0;
              werr_d  = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (din != pred) begin
            err_pulse_d = 1'b1;
            werr_inc    = werr_q + WERR_W'(1);
            if (err_count_q != {CNT_W{1'b1}}) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
          end
          wbit_d = wbit_q + WIN_LOG2'(1);
          if (32'(werr_inc) >= 32'(LOSS_ERRS)) begin
            state_d      = SEARCH;
            fill_d       = '0;
            werr_d       = '0;
            lost_pulse_d = 1'b1;
          end else if (wbit_q == {WIN_LOG2{1'b1}}) begin
            werr_d = '0;
          end else begin
            werr_d = werr_inc;
          end
        end
        default: begin
          state_d = SEARCH;
          fill_d  = '0;
        end
      endcase
    end

    if (err_clr) begin
      err_count_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      s_q          <= '0;
      fill_q       <= '0;
      match_q      <= '0;
      wbit_q       <= '0;
      werr_q       <= '0;
      err_count_q  <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      lost_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      fill_q       <= fill_d;
      match_q      <= match_d;
      wbit_q       <= wbit_d;
      werr_q       <= werr_d;
      err_count_q  <= err_count_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      lost_pulse_q <= lost_pulse_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign lost_pulse = lost_pulse_q;
  assign err_count  = err_count_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/prbs31_checker.md
# prbs31_checker

Self-synchronising PRBS31 (x^31 + x^28 + 1) receive checker, the stage directly downstream of the PRBS31 generator in the tt_um_davidparent_prbs31 project. Consumes one serial bit per valid cycle, acquires lock on the sequence, then counts bit errors and detects loss of lock. Status and error count feed the tile's output pins through the top-level wrapper.

## Interface

Parameters:
- LOCK_CNT, 64: consecutive matching bits in VERIFY required to declare lock.
- LOSS_ERRS, 8: errors within one window that force loss of lock.
- WIN_LOG2, 5: window length is 2^WIN_LOG2 valid bits.
- CNT_W, 16: width of the error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- din  in  1  received serial bit.
- din_vld  in  1  din is sampled only when high.
- err_clr  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per errored bit while LOCKED.
- lost_pulse  out  1  one-cycle pulse on LOCKED -> SEARCH transition.
- err_count  out  CNT_W  saturating count of errored bits.

## Operation

- Shift register s[30:0], s[0] newest bit. Predicted bit p = s[30] ^ s[27].
- All state advances only on cycles with din_vld=1; with din_vld=0 every register holds (except err_clr and single-cycle pulses, which clear).
- SEARCH: shift din into s; fill counter counts to 31; on the 31st valid bit go to VERIFY with match counter 0.
- VERIFY: compare din to p; shift din (not p) into s. Match and s != 0 -> match counter +1; mismatch or s == 0 -> match counter := 0, stay in VERIFY. Counter reaching LOCK_CNT -> LOCKED, window counters 0.
- LOCKED: shift p (free-running generator) into s, so one line error yields exactly one error. din != p -> err_pulse, err_count +1 (saturating at 2^CNT_W-1), window error count +1.
- Window: bit counter wraps every 2^WIN_LOG2 valid bits; window error count resets at wrap. Window error count reaching LOSS_ERRS -> SEARCH, fill counter 0, lost_pulse. err_count is retained across loss of lock.
- err_clr: err_count := 0 next edge; takes priority over a simultaneous increment (err_pulse still fires).
- Reset values: state SEARCH, s = 0, all counters 0, locked = 0, err_pulse = 0, lost_pulse = 0, err_count = 0. Reset asserted mid-operation forces these values at the next edge regardless of din_vld.

## Timing

- All outputs registered; no combinational input-to-output path.
- locked rises the cycle after the valid cycle carrying the LOCK_CNT-th match; from clean start that is 31 + LOCK_CNT valid bits (95 by default).
- err_pulse and err_count update the cycle after the errored bit is sampled.
- locked falls and lost_pulse asserts the cycle after the bit producing the LOSS_ERRS-th window error; that bit is still counted in err_count.
- Re-acquisition after loss takes at least 31 + LOCK_CNT further valid bits.

## Structure

- Shared package prbs31_pkg: state enum (SEARCH, VERIFY, LOCKED), polynomial tap constants (31, 28), PRBS_LEN = 31. The generator block uses the same package.
- One natural sub-module: prbs31_lfsr_step (combinational next-state and predicted bit from s), shared with the generator.
- Expected size 150-250 lines RTL.

## Test plan

- Reset: rst_n low 2 cycles with random din/din_vld -> locked=0, err_pulse=0, lost_pulse=0, err_count=0.
- Clean PRBS31 from seed 0x7FFFFFFF, din_vld=1 continuously -> locked rises the cycle after bit 95; err_count stays 0 over 10000 bits; repeat with din_vld randomly 50% -> same 95 valid bits to lock.
- After lock, flip one bit -> exactly one err_pulse, err_count=1, locked stays 1.
- All-zero input for 500 bits -> locked never asserts.
- After lock, switch to inverted stream -> lost_pulse within 32 bits, err_count=8; then clean stream -> relock after 95 more valid bits, err_count still 8.
- CNT_W=4 override, continuous errors with LOSS_ERRS=255 -> err_count saturates at 15; err_clr coincident with an error -> err_count=0, err_pulse=1.
